config_sram_loader: RTL and testbench
=====================================

Name: config_sram_loader

Overview:
- Transmit-side driver for the SRAM configuration shift chain, i.e. the block that feeds the `config_sram_data` chain.
- Accepts parallel (address, data, conf) words over a valid/ready handshake. Serializes each word onto `shift_in` with `shift_enable` asserted, then strobes `config_set` to commit the write.
- Captures the bits returning on `shift_out` and presents them as a readback word for chain integrity checks.
- Sits between the configuration controller and the SRAM config chain.

Parameters:
- ADDR_BITS, 10: address field width; must match the chain's address shifter.
- DATA_BITS, 32: data field width; must match the chain's data shifter.
- COMMIT_CYCLES, 1: number of cycles `config_set` is held high per word (>=1).

Ports:
- cclk  input  1  configuration clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  word available.
- in_ready  output  1  loader can accept a word.
- in_addr  input  ADDR_BITS  target SRAM address.
- in_data  input  DATA_BITS  write data.
- in_conf  input  2  SRAM mode bits for this word.
- shift_enable  output  1  chain shift strobe.
- shift_in  output  1  serial bit into chain.
- shift_out  input  1  serial bit returning from chain end.
- config_set  output  1  commit strobe (chain write_enable).
- sram_conf  output  2  mode bits, held from accept until next accept.
- busy  output  1  high in SHIFT or COMMIT.
- rb_valid  output  1  one-cycle pulse: readback word valid.
- rb_addr  output  ADDR_BITS  previous chain address content.
- rb_data  output  DATA_BITS  previous chain data content.

Behaviour:
- N = ADDR_BITS + DATA_BITS.
- Internal state: N-bit shift register `sreg`; down-counter sized for max(N, COMMIT_CYCLES).
- Reset (rst==0 at an edge) forces:
  - state = IDLE
  - in_ready = 1
  - shift_enable = 0, config_set = 0, shift_in = 0, busy = 0
  - rb_valid = 0, rb_addr = 0, rb_data = 0
  - sram_conf = 0, sreg = 0
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - in_ready = 1.
  - On an edge where in_valid=1: load sreg = {in_data, in_addr}, latch sram_conf = in_conf, counter = N-1, go to SHIFT.
- SHIFT:
  - in_ready = 0, shift_enable = 1, shift_in = sreg[N-1].
  - Each edge: sreg <= {sreg[N-2:0], shift_out}, counter decrements.
  - When counter == 0 at the edge, go to COMMIT with counter = COMMIT_CYCLES-1.
  - SHIFT lasts exactly N cycles.
- Stream order:
  - Data bits go out first, MSB first, then address bits, MSB first.
  - After N shifts the chain holds write_data = in_data and write_address = in_addr.
- COMMIT:
  - shift_enable = 0, config_set = 1, shift_in = 0.
  - When counter == 0 at the edge: go to IDLE, pulse rb_valid for one cycle with rb_data = sreg[N-1:ADDR_BITS], rb_addr = sreg[ADDR_BITS-1:0].
- Readback content: the word shifted out is the chain's prior contents, in the same {data, addr} format.
- Outputs are registered: shift_enable, shift_in, config_set and rb_* change only on cclk edges.
- Timing:
  - Word accepted at edge E.
  - shift_enable is high for cycles E+1 .. E+N.
  - config_set is high for cycles E+N+1 .. E+N+COMMIT_CYCLES.
  - rb_valid and in_ready are high in cycle E+N+COMMIT_CYCLES+1.
  - Throughput: one word per N+COMMIT_CYCLES+1 cycles.
- Handshake:
  - in_valid while not ready is ignored.
  - in_addr, in_data and in_conf are sampled only at the accepting edge; later input changes have no effect.
- Simultaneous events:
  - The rb_valid cycle is an IDLE cycle; a new word may be accepted in it.
  - Reset has priority over everything.
- Reset mid-operation (SHIFT or COMMIT):
  - Next cycle shift_enable = 0 and config_set = 0.
  - No commit occurs and no rb_valid pulse is issued.
  - The chain is left partially shifted; the controller must resend.
- shift_out is sampled only in SHIFT.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=1, shift_enable=0, config_set=0, rb_valid=0, sram_conf=0.
- Single word (ADDR_BITS=4, DATA_BITS=8), chain model preloaded with addr=0x0, data=0x00; send addr=0xA, data=0x5C, conf=2'b10:
  - shift_in sequence over 12 cycles is 0,1,0,1,1,1,0,0,1,0,1,0.
  - config_set is high for 1 cycle; model commits mem[0xA]=0x5C; sram_conf=2'b10.
  - rb_valid is high with rb_addr=0x0, rb_data=0x00.
- Back-to-back: send (0x3, 0xFF) then (0x4, 0x81), with in_valid held high:
  - Second word is accepted on the rb_valid cycle of the first.
  - Second readback gives rb_addr=0x3, rb_data=0xFF.
  - Accept spacing is exactly 14 cycles.
- COMMIT_CYCLES=3: config_set is high for exactly 3 consecutive cycles; shift_enable is 0 throughout that window.
- Reset mid-SHIFT: assert rst=0 at shift cycle 5 -> shift_enable=0 and config_set=0 the next cycle; no rb_valid pulse; the model records no write.
- Input stability: change in_data during SHIFT -> transmitted bits still match the value latched at accept.

Source files
------------

// File: rtl/config_sram_loader.sv
// Transmit-side driver for the SRAM configuration shift chain: serializes {data, addr}
// words MSB first, strobes config_set to commit, and returns the displaced chain word.
module config_sram_loader #(
    parameter int ADDR_BITS     = 10,
    parameter int DATA_BITS     = 32,
    parameter int COMMIT_CYCLES = 1
) (
    input  logic                 cclk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic [1:0]           in_conf,
    output logic                 shift_enable,
    output logic                 shift_in,
    input  logic                 shift_out,
    output logic                 config_set,
    output logic [1:0]           sram_conf,
    output logic                 busy,
    output logic                 rb_valid,
    output logic [ADDR_BITS-1:0] rb_addr,
    output logic [DATA_BITS-1:0] rb_data
);

    localparam int N       = ADDR_BITS + DATA_BITS;
    localparam int CNT_MAX = (N > COMMIT_CYCLES) ? N : COMMIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t          state;
    logic [N-1:0]    sreg;
    logic [CW-1:0]   count;

    // shift_in is registered from the next bit of sreg so it always equals sreg[N-1] while shifting
    always_ff @(posedge cclk) begin
        if (!rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            shift_enable <= 1'b0;
            shift_in     <= 1'b0;
            config_set   <= 1'b0;
            busy         <= 1'b0;
            rb_valid     <= 1'b0;
            rb_addr      <= '0;
            rb_data      <= '0;
            sram_conf    <= 2'b00;
            sreg         <= '0;
            count        <= '0;
        end else begin
            rb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg         <= {in_data, in_addr};
                        sram_conf    <= in_conf;
                        count        <= CW'(N - 1);
                        shift_in     <= in_data[DATA_BITS-1];
                        shift_enable <= 1'b1;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= {sreg[N-2:0], shift_out};
                    if (count == '0) begin
                        state        <= COMMIT;
                        count        <= CW'(COMMIT_CYCLES - 1);
                        shift_enable <= 1'b0;
                        shift_in     <= 1'b0;
                        config_set   <= 1'b1;
                    end else begin
                        count    <= count - CW'(1);
                        shift_in <= sreg[N-2];
                    end
                end
                COMMIT: begin
                    if (count == '0) begin
                        state      <= IDLE;
                        config_set <= 1'b0;
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                        rb_valid   <= 1'b1;
                        rb_data    <= sreg[N-1:ADDR_BITS];
                        rb_addr    <= sreg[ADDR_BITS-1:0];
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_sram_loader.sv
// Scoreboard bench for config_sram_loader: a behavioural chain model feeds shift_out,
// expected serial bits and readback words are queued at accept and checked on output.
module tb_config_sram_loader;

    localparam int AB = 4;
    localparam int DB = 8;
    localparam int N  = AB + DB;

    logic          cclk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [AB-1:0] in_addr;
    logic [DB-1:0] in_data;
    logic [1:0]    in_conf;
    logic          in_ready, shift_enable, shift_in, shift_out, config_set, busy, rb_valid;
    logic [1:0]    sram_conf;
    logic [AB-1:0] rb_addr;
    logic [DB-1:0] rb_data;

    logic          v3;
    logic          ready3, se3, si3, cs3, busy3, rbv3;
    logic          so3 = 1'b0;
    logic [1:0]    conf3;
    logic [AB-1:0] rba3;
    logic [DB-1:0] rbd3;

    int vectors = 0;
    int miscompares = 0;

    always #5 cclk = ~cclk;

    config_sram_loader #(.ADDR_BITS(AB), .DATA_BITS(DB), .COMMIT_CYCLES(1)) dut (
        .cclk(cclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_conf(in_conf),
        .shift_enable(shift_enable), .shift_in(shift_in), .shift_out(shift_out),
        .config_set(config_set), .sram_conf(sram_conf), .busy(busy),
        .rb_valid(rb_valid), .rb_addr(rb_addr), .rb_data(rb_data)
    );

    config_sram_loader #(.ADDR_BITS(AB), .DATA_BITS(DB), .COMMIT_CYCLES(3)) dut3 (
        .cclk(cclk), .rst(rst), .in_valid(v3), .in_ready(ready3),
        .in_addr(in_addr), .in_data(in_data), .in_conf(in_conf),
        .shift_enable(se3), .shift_in(si3), .shift_out(so3),
        .config_set(cs3), .sram_conf(conf3), .busy(busy3),
        .rb_valid(rbv3), .rb_addr(rba3), .rb_data(rbd3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Chain model: shifts on shift_enable, writes its data field into mem on config_set
    logic [N-1:0]  chain = '0;
    logic [DB-1:0] mem [16];
    int            writes = 0;
    assign shift_out = chain[N-1];

    always @(posedge cclk) begin
        if (shift_enable === 1'b1) chain <= {chain[N-2:0], shift_in};
        if (config_set === 1'b1) begin
            mem[chain[AB-1:0]] <= chain[N-1:AB];
            writes <= writes + 1;
        end
    end

    int           cyc = 0;
    int           acc_count = 0;
    int           acc_cyc_prev = 0;
    int           acc_cyc_last = 0;
    logic         acc_flag = 1'b0;
    logic         rst_edge = 1'b0;
    logic [N-1:0] acc_word, acc_chain;

    always @(posedge cclk) begin
        cyc++;
        rst_edge = (rst === 1'b0);
        acc_flag = (rst === 1'b1) && (in_valid === 1'b1) && (in_ready === 1'b1);
        if (acc_flag) begin
            acc_word     = {in_data, in_addr};
            acc_chain    = chain;
            acc_cyc_prev = acc_cyc_last;
            acc_cyc_last = cyc;
            acc_count++;
        end
    end

    logic         bit_q [$];
    logic [N-1:0] rb_q [$];
    int           cs_run = 0;
    int           rb_count = 0;
    logic [N-1:0] last_rb = '0;
    logic [N-1:0] exp_rb;

    always @(negedge cclk) begin
        if (rst_edge) begin
            bit_q.delete();
            rb_q.delete();
            cs_run = 0;
        end
        if (acc_flag) begin
            for (int i = N - 1; i >= 0; i--) bit_q.push_back(acc_word[i]);
            rb_q.push_back(acc_chain);
        end
        if (shift_enable === 1'b1) begin
            if (bit_q.size() == 0) checkOutput("shift_bits_left", 32'(bit_q.size()), 32'd1);
            else checkOutput("shift_in", shift_in, bit_q.pop_front());
        end
        if (config_set === 1'b1) begin
            if (cs_run == 0) checkOutput("bits_at_commit", 32'(bit_q.size()), 32'd0);
            checkOutput("se_in_commit", shift_enable, 1'b0);
            cs_run++;
        end else if (cs_run != 0) begin
            checkOutput("commit_len", cs_run, 1);
            cs_run = 0;
        end
        if (rb_valid === 1'b1) begin
            rb_count++;
            last_rb = {rb_data, rb_addr};
            if (rb_q.size() == 0) begin
                checkOutput("rb_expected_left", 32'(rb_q.size()), 32'd1);
            end else begin
                exp_rb = rb_q.pop_front();
                checkOutput("rb_data", rb_data, exp_rb[N-1:AB]);
                checkOutput("rb_addr", rb_addr, exp_rb[AB-1:0]);
                checkOutput("rb_in_ready", in_ready, 1'b1);
            end
        end
    end

    int run3 = 0;
    int commits3 = 0;
    int se3_count = 0;
    int rb3_count = 0;

    always @(negedge cclk) begin
        if (se3 === 1'b1) se3_count++;
        if (rbv3 === 1'b1) rb3_count++;
        if (cs3 === 1'b1) begin
            checkOutput("cc3_se_in_commit", se3, 1'b0);
            run3++;
        end else if (run3 != 0) begin
            checkOutput("cc3_commit_len", run3, 3);
            commits3++;
            run3 = 0;
        end
    end

    task automatic waitReady(input string tag);
        int n = 0;
        while (!(in_ready === 1'b1 && busy === 1'b0) && n < 100) begin
            @(negedge cclk);
            n++;
        end
        checkOutput(tag, {busy, in_ready}, 2'b01);
        @(negedge cclk);
    endtask

    task automatic waitAccept(input int target);
        int n = 0;
        while (acc_count < target && n < 40) begin
            @(negedge cclk);
            n++;
        end
        checkOutput("accept_count", acc_count, target);
    endtask

    task automatic applyStimulus(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [1:0] c);
        in_addr  = a;
        in_data  = d;
        in_conf  = c;
        in_valid = 1'b1;
        @(negedge cclk);
        in_valid = 1'b0;
    endtask

    int writes_before;
    int rb_before;
    int n3;

    initial begin
        rst = 1'b0;
        in_valid = 1'b1;
        v3 = 1'b0;
        in_addr = '0;
        in_data = '0;
        in_conf = 2'b00;
        repeat (3) @(negedge cclk);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_shift_enable", shift_enable, 1'b0);
        checkOutput("rst_config_set", config_set, 1'b0);
        checkOutput("rst_rb_valid", rb_valid, 1'b0);
        checkOutput("rst_sram_conf", sram_conf, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge cclk);

        $display("[TB] single word");
        applyStimulus(4'hA, 8'h5C, 2'b10);
        in_data = 8'hFF;
        in_addr = 4'h0;
        waitReady("word1_done");
        checkOutput("word1_mem", mem[4'hA], 8'h5C);
        checkOutput("word1_writes", writes, 1);
        checkOutput("word1_sram_conf", sram_conf, 2'b10);
        checkOutput("word1_rb", last_rb, 12'h000);

        $display("[TB] back-to-back");
        in_addr  = 4'h3;
        in_data  = 8'hFF;
        in_conf  = 2'b01;
        in_valid = 1'b1;
        waitAccept(2);
        @(negedge cclk);
        in_addr = 4'h4;
        in_data = 8'h81;
        in_conf = 2'b11;
        waitAccept(3);
        in_valid = 1'b0;
        checkOutput("accept_spacing", acc_cyc_last - acc_cyc_prev, 14);
        waitReady("b2b_done");
        checkOutput("b2b_rb", last_rb, 12'hFF3);
        checkOutput("b2b_mem3", mem[4'h3], 8'hFF);
        checkOutput("b2b_mem4", mem[4'h4], 8'h81);
        checkOutput("b2b_sram_conf", sram_conf, 2'b11);

        $display("[TB] reset mid-shift");
        writes_before = writes;
        rb_before = rb_count;
        applyStimulus(4'h7, 8'h3C, 2'b01);
        repeat (4) @(negedge cclk);
        rst = 1'b0;
        @(negedge cclk);
        checkOutput("midrst_shift_enable", shift_enable, 1'b0);
        checkOutput("midrst_config_set", config_set, 1'b0);
        checkOutput("midrst_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        repeat (20) @(negedge cclk);
        checkOutput("midrst_writes", writes, writes_before);
        checkOutput("midrst_rb_count", rb_count, rb_before);

        applyStimulus(4'h1, 8'h42, 2'b11);
        waitReady("post_rst_done");
        checkOutput("post_rst_rb", last_rb, 12'h287);
        checkOutput("post_rst_mem", mem[4'h1], 8'h42);

        $display("[TB] commit cycles = 3");
        n3 = 0;
        while (!(ready3 === 1'b1) && n3 < 100) begin
            @(negedge cclk);
            n3++;
        end
        in_addr = 4'h5;
        in_data = 8'h99;
        in_conf = 2'b10;
        v3 = 1'b1;
        @(negedge cclk);
        v3 = 1'b0;
        n3 = 0;
        while (!(ready3 === 1'b1 && busy3 === 1'b0) && n3 < 100) begin
            @(negedge cclk);
            n3++;
        end
        @(negedge cclk);
        checkOutput("cc3_done", {busy3, ready3}, 2'b01);
        checkOutput("cc3_commits", commits3, 1);
        checkOutput("cc3_shift_cycles", se3_count, N);
        checkOutput("cc3_rb_count", rb3_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
